// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RW_BIT = 9;
  localparam int LCD_RS_BIT = 8;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Clear and return-home are the slow instructions on the controller.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty decode from the count.
module lcd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: drains the store FIFO and times every EN pulse and post-command wait.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 40,
  parameter int CLR_WAIT_CYC = 1600
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     lcd_on_i,
  input  logic                     wr_valid_i,
  input  logic [8:0]               wr_data_i,
  output logic                     wr_ready_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [31:0]              io_lcd_o
);

  localparam int MAXC = max2(max2(SETUP_CYC, PULSE_CYC),
                             max2(HOLD_CYC, max2(CMD_WAIT_CYC, CLR_WAIT_CYC)));
  localparam int CW   = $clog2(MAXC + 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    hold_q;
  logic [8:0]    fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction

  lcd_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (wr_valid_i),
    .wr_data (wr_data_i),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  // Counter is reloaded on every state entry and each state exits when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SETUP;
          cnt_d   = ld(SETUP_CYC);
          pop     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = ld(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = ld(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = is_long_cmd(hold_q[8], hold_q[7:0]) ? ld(CLR_WAIT_CYC) : ld(CMD_WAIT_CYC);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            state_d = ST_SETUP;
            cnt_d   = ld(SETUP_CYC);
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) hold_q <= fifo_rd;
    end
  end

  always_comb begin
    io_lcd_o             = '0;
    io_lcd_o[LCD_ON_BIT] = lcd_on_i;
    io_lcd_o[LCD_EN_BIT] = (state_q == ST_PULSE);
    io_lcd_o[LCD_RW_BIT] = 1'b0;
    io_lcd_o[LCD_RS_BIT] = hold_q[8];
    io_lcd_o[7:0]        = hold_q[7:0];
  end

  assign wr_ready_o = !fifo_full;
  assign busy_o     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: reset/first-transfer table, directed timing sequences, random traffic vs a timeline model.
module tb_lcd_ctrl;

  localparam int DEPTH        = 8;
  localparam int SETUP_CYC    = 2;
  localparam int PULSE_CYC    = 12;
  localparam int HOLD_CYC     = 2;
  localparam int CMD_WAIT_CYC = 40;
  localparam int CLR_WAIT_CYC = 1600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_on;
  logic        wr_valid;
  logic [8:0]  wr_data;
  logic        wr_ready;
  logic        busy;
  logic [3:0]  level;
  logic [31:0] io;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .lcd_on_i(lcd_on), .wr_valid_i(wr_valid),
    .wr_data_i(wr_data), .wr_ready_o(wr_ready), .busy_o(busy), .level_o(level), .io_lcd_o(io)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: queue of accepted words plus the start edge and length of the transfer in flight.
  logic [8:0] mq[$];
  bit         m_active = 1'b0;
  int         m_start  = 0;
  int         m_period = 0;
  logic [8:0] m_cur    = '0;

  // Watch queues for EN edges and the last busy fall seen.
  int         rise_q[$];
  logic [8:0] rise_dat[$];
  int         efall_q[$];
  int         busy_fall = -1;
  logic       prev_en = 1'b0;

  typedef struct {
    logic        rst_n;
    logic        on;
    logic        v;
    logic [8:0]  d;
    logic [31:0] e_io;
    logic        e_rdy;
    logic [3:0]  e_lvl;
    logic        e_busy;
  } vec_t;

  vec_t tbl[8];

  function automatic int period_of(input logic [8:0] w);
    int wt;
    wt = (!w[8] && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
    return SETUP_CYC + PULSE_CYC + HOLD_CYC + wt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = (mq.size() < DEPTH);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_cur    = '0;
      return;
    end
    if (m_active && cyc == m_start + m_period) m_active = 1'b0;
    if (!m_active && mq.size() > 0) begin
      m_cur    = mq.pop_front();
      m_active = 1'b1;
      m_start  = cyc;
      m_period = period_of(m_cur);
    end
    if (wr_valid && rdy) mq.push_back(wr_data);
  endtask

  task automatic model_check();
    int          off;
    logic        en;
    logic [31:0] e_io;
    off  = cyc - m_start;
    en   = m_active && off >= SETUP_CYC && off < SETUP_CYC + PULSE_CYC;
    e_io = {lcd_on, 20'b0, en, 1'b0, m_cur};
    chk("model_io", io, e_io);
    chk("model_ready", {31'b0, wr_ready}, {31'b0, mq.size() < DEPTH});
    chk("model_level", 32'(level), 32'(mq.size()));
    chk("model_busy", {31'b0, busy}, {31'b0, m_active || mq.size() > 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
    if (io[10] && !prev_en) begin
      rise_q.push_back(cyc);
      rise_dat.push_back(io[8:0]);
    end
    if (!io[10] && prev_en) efall_q.push_back(cyc);
    prev_en = io[10];
  endtask

  task automatic clear_watch();
    rise_q.delete();
    rise_dat.delete();
    efall_q.delete();
    busy_fall = -1;
  endtask

  task automatic run_until_idle(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (!busy) begin
        busy_fall = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL idle_timeout at cycle %0d: busy still 1 after %0d cycles, required 0", cyc, max);
  endtask

  task automatic push_one(input logic [8:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  int p;
  logic [8:0] w;

  initial begin
    rst_n = 1'b0; lcd_on = 1'b0; wr_valid = 1'b0; wr_data = '0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 1'b1, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 9'h000, 32'h8000_0000, 1'b1, 4'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 9'h038, 32'h8000_0000, 1'b1, 4'd1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 9'h000, 32'h8000_0038, 1'b1, 4'd0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 9'h000, 32'h8000_0038, 1'b1, 4'd0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 9'h000, 32'h8000_0438, 1'b1, 4'd0, 1'b1};

    clear_watch();
    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n; lcd_on = tbl[i].on; wr_valid = tbl[i].v; wr_data = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_io", i), io, tbl[i].e_io);
      chk($sformatf("tbl%0d_ready", i), {31'b0, wr_ready}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
    end
    wr_valid = 1'b0;

    // Single command: SETUP entered at edge 6, EN 8..19, idle 56 cycles after SETUP.
    run_until_idle(200);
    chk("single_rises", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() > 0) chk("single_rise_cyc", 32'(rise_q[0]), 32'd8);
    if (efall_q.size() > 0) chk("single_en_fall", 32'(efall_q[0]), 32'd20);
    chk("single_busy_fall", 32'(busy_fall), 32'd62);

    // Clear command: long wait after the pulse.
    clear_watch();
    push_one(9'h001);
    p = cyc;
    run_until_idle(3000);
    chk("clear_rises", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() > 0) chk("clear_rise_cyc", 32'(rise_q[0]), 32'(p + 3));
    chk("clear_busy_fall", 32'(busy_fall), 32'(p + 1 + 1616));

    // Back-to-back data words.
    clear_watch();
    p = cyc + 1;
    push_one(9'h13F);
    push_one(9'h106);
    push_one(9'h15B);
    run_until_idle(400);
    chk("b2b_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      chk("b2b_rise0", 32'(rise_q[0]), 32'(p + 3));
      chk("b2b_rise1", 32'(rise_q[1]), 32'(p + 3 + 56));
      chk("b2b_rise2", 32'(rise_q[2]), 32'(p + 3 + 112));
      chk("b2b_dat0", 32'(rise_dat[0]), 32'h13F);
      chk("b2b_dat1", 32'(rise_dat[1]), 32'h106);
      chk("b2b_dat2", 32'(rise_dat[2]), 32'h15B);
    end

    // Overflow: one in flight, ten offered, eight accepted.
    clear_watch();
    p = cyc + 1;
    push_one(9'h041);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 9'(9'h150 + i);
      step();
      if (i == 7) begin
        chk("ovf_ready_full", {31'b0, wr_ready}, 32'd0);
        chk("ovf_level_full", 32'(level), 32'd8);
      end
    end
    wr_valid = 1'b0;
    chk("ovf_level_after", 32'(level), 32'd8);
    run_until_idle(1000);
    chk("ovf_rises", 32'(rise_q.size()), 32'd9);
    chk("ovf_busy_fall", 32'(busy_fall), 32'(p + 1 + 9 * 56));

    // Reset while EN is high.
    clear_watch();
    push_one(9'h148);
    push_one(9'h149);
    for (int i = 0; i < 20 && !io[10]; i++) step();
    chk("rst_en_reached", {31'b0, io[10]}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_en", {31'b0, io[10]}, 32'd0);
    chk("rst_io_low", {1'b0, io[30:0]}, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    clear_watch();
    for (int i = 0; i < 200; i++) step();
    chk("rst_no_pulses", 32'(rise_q.size()), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Random traffic checked every cycle against the timeline model.
    for (int i = 0; i < 5000; i++) begin
      rst_n = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 49) == 0) lcd_on = ~lcd_on;
      wr_valid = ($urandom_range(0, 11) == 0);
      w = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 15) == 0) w = {1'b0, 8'($urandom_range(1, 3))};
      else if (!w[8] && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) w[4] = 1'b1;
      wr_data = w;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
